// File: rtl/fetch_pc_unit.sv
// Instruction fetch: owns the fetch PC, issues one imem request at a time and
// fills the IF/ID register, with a one-entry skid for responses that arrive under stall.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_INC   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] INC = 32'(PC_INC);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inflight_q, inflight_d;
  logic        drop_q, drop_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d;
  logic        load_en;
  logic [31:0] load_pc, load_instr;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inflight_d   = inflight_q;
    drop_d       = drop_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    if_valid_d   = if_valid_q;
    load_en      = 1'b0;
    load_pc      = inflight_q;
    load_instr   = imem_rdata;

    if (redirect_valid) begin
      // Redirect beats stall; anything fetched from the old path is wrong-path.
      pc_d       = redirect_pc & ~32'h3;
      if_valid_d = 1'b0;
      unique case (state_q)
        S_REQ: begin
          if (imem_gnt) begin
            inflight_d = pc_q;
            drop_d     = 1'b1;
            state_d    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d = 1'b1;
          end
        end
        S_HOLD:  state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (imem_gnt) begin
            inflight_d = pc_q;
            pc_d       = pc_q + INC;
            state_d    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = S_REQ;
            end else if (!stall) begin
              load_en    = 1'b1;
              load_pc    = inflight_q;
              load_instr = imem_rdata;
              state_d    = S_REQ;
            end else begin
              skid_pc_d    = inflight_q;
              skid_instr_d = imem_rdata;
              state_d      = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            load_en    = 1'b1;
            load_pc    = skid_pc_q;
            load_instr = skid_instr_q;
            state_d    = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase

      // Unstalled IF/ID either takes a new instruction or its entry is consumed.
      if (!stall) begin
        if (load_en) begin
          if_pc_d    = load_pc;
          if_instr_d = load_instr;
          if_valid_d = 1'b1;
        end else begin
          if_valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0;
      if_instr_q <= NOP;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  always_ff @(posedge clk) begin
    inflight_q   <= inflight_d;
    skid_pc_q    <= skid_pc_d;
    skid_instr_q <= skid_instr_d;
  end

  assign imem_req  = (state_q == S_REQ) && !rst;
  assign imem_addr = pc_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  assign if_valid  = if_valid_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized scoreboard bench for fetch_pc_unit: expected fetch stream is queued
// at each redirect/reset and a monitor checks every instruction entering IF/ID.
module tb_fetch_pc_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;

  fetch_pc_unit #(.RESET_PC(RESET_PC), .PC_INC(4)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid)
  );

  int n_checks = 0;
  int n_fail = 0;
  int deliveries = 0;
  logic [31:0] exp_q[$];

  int gnt_pct = 100;
  int max_d = 1;
  bit pend = 0;
  int cnt = 0;
  logic [31:0] paddr = 32'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0004) return 32'h0050_0093;
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected architectural fetch stream from a new start address.
  task automatic flush(input logic [31:0] base);
    logic [31:0] a;
    exp_q.delete();
    a = base & ~32'h3;
    for (int i = 0; i < 128; i++) begin
      exp_q.push_back(a);
      a = a + 32'd4;
    end
  endtask

  // Memory: grants only with nothing pending, answers 1..max_d cycles after the grant.
  initial begin
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      if (imem_req && imem_gnt) begin
        pend = 1;
        cnt = $urandom_range(max_d, 1);
        paddr = imem_addr;
      end
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata = mem_word(paddr);
          pend = 0;
        end
      end
      imem_gnt = !pend && ($urandom_range(99, 0) < gnt_pct);
    end
  end

  // Monitor: a new IF/ID entry can only appear after an unstalled, non-reset edge.
  initial begin
    logic ps, pr;
    logic [31:0] e;
    forever begin
      @(posedge clk);
      ps = stall;
      pr = rst;
      #1;
      if (if_valid && !ps && !pr) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_instr: got pc %08h with empty expectation queue", if_pc);
        end else begin
          e = exp_q.pop_front();
          check("if_pc", if_pc, e);
          check("if_instr", if_instr, mem_word(e));
        end
        deliveries++;
      end
      if (imem_req) check("imem_addr_align", {30'h0, imem_addr[1:0]}, 32'h0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int since_redir;
    int d0;
    bit found;
    logic [31:0] tgt;
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    flush(RESET_PC);

    @(negedge clk);
    check("req_in_reset", {31'h0, imem_req}, 32'h0);
    rst = 1'b0;
    #1;
    check("rst_if_valid", {31'h0, if_valid}, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, 32'h0000_0013);
    check("rst_imem_req", {31'h0, imem_req}, 32'h1);
    check("rst_imem_addr", imem_addr, RESET_PC);

    // Immediate grant, 1-cycle response: IF/ID valid every other cycle.
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #2;
      check($sformatf("latency_valid_%0d", i), {31'h0, if_valid}, (i % 2 == 0) ? 32'h1 : 32'h0);
    end

    // Randomized phase: stalls, variable grant/response timing, redirects incl. wrap region.
    @(negedge clk);
    gnt_pct = 70;
    max_d = 3;
    since_redir = 0;
    for (int c = 0; c < 3000; c++) begin
      stall = ($urandom_range(99, 0) < 30);
      since_redir++;
      if (($urandom_range(99, 0) < 3) || since_redir > 90) begin
        since_redir = 0;
        tgt = ($urandom_range(1, 0) == 1) ? (32'hFFFF_FFE0 | 32'($urandom_range(31, 0)))
                                           : $urandom;
        redirect_valid = 1'b1;
        redirect_pc = tgt;
        flush(tgt);
      end else begin
        redirect_valid = 1'b0;
      end
      @(negedge clk);
    end
    stall = 1'b0;
    redirect_valid = 1'b0;
    repeat (10) @(negedge clk);

    // Reset while a request is outstanding: the stale response must never reach IF/ID.
    gnt_pct = 100;
    max_d = 3;
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(posedge clk);
      #2;
      if (pend && !imem_req) found = 1;
    end
    check("found_wait_before_reset", {31'h0, found}, 32'h1);
    gnt_pct = 0;
    rst = 1'b1;
    flush(RESET_PC);
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int k = 0; k < 10 && pend; k++) begin
      @(posedge clk);
      #2;
    end
    repeat (2) @(posedge clk);
    #2;
    check("post_rst_if_valid", {31'h0, if_valid}, 32'h0);
    check("post_rst_imem_req", {31'h0, imem_req}, 32'h1);
    check("post_rst_imem_addr", imem_addr, RESET_PC);
    d0 = deliveries;
    gnt_pct = 100;
    repeat (12) @(posedge clk);
    #2;
    check("post_rst_progress", {31'h0, deliveries > d0}, 32'h1);
    check("total_deliveries", {31'h0, deliveries > 100}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
